// File: rtl/pe_uno_ctrl.sv
// Sequencing controller for the unified gemm/div/exp/log processing element.
// Define UNO_CTRL_PERF_EN to add the saturating op_cnt_o completion counter.
module pe_uno_ctrl #(
  parameter int MUL_BW  = 16,
  parameter int ITER_BW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [MUL_BW-1:0]  req_x,
  input  logic [ITER_BW-1:0] req_iter,
  output logic [1:0]         gemm_uno_o,
  output logic [MUL_BW-1:0]  x_o,
  output logic               acc_clr_o,
  output logic               acc_en_o,
  output logic [ITER_BW-1:0] iter_idx_o,
  output logic               done_valid,
  input  logic               done_ready,
  output logic               busy_o
`ifdef UNO_CTRL_PERF_EN
  ,
  output logic [31:0]        op_cnt_o
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OFFSET = 3'd1;
  localparam logic [2:0] S_ITER   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [ITER_BW-1:0] ONE = ITER_BW'(1);

  logic [2:0]         state;
  logic [1:0]         op_q;
  logic [MUL_BW-1:0]  x_q;
  logic [ITER_BW-1:0] n_q;
  logic [ITER_BW-1:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
      x_q   <= '0;
      n_q   <= ONE;
      idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            x_q   <= req_x;
            n_q   <= (req_iter == '0) ? ONE : req_iter;
            state <= (req_op == 2'b00) ? S_ITER : S_OFFSET;
          end
        end
        S_OFFSET: state <= S_ITER;
        S_ITER: begin
          if (idx_q == n_q - ONE) begin
            idx_q <= '0;
            state <= S_DRAIN;
          end else begin
            idx_q <= idx_q + ONE;
          end
        end
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          if (done_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // gemm has no offset phase, so it clears on its first accumulate cycle
  assign acc_clr_o  = (state == S_OFFSET) ||
                      ((state == S_ITER) && (op_q == 2'b00) &&
                       (idx_q == '0));
  assign acc_en_o   = (state == S_ITER);
  assign iter_idx_o = (state == S_ITER) ? idx_q : '0;
  assign req_ready  = (state == S_IDLE);
  assign done_valid = (state == S_DONE);
  assign busy_o     = (state != S_IDLE);
  assign gemm_uno_o = op_q;
  assign x_o        = x_q;

`ifdef UNO_CTRL_PERF_EN
  logic [31:0] op_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= '0;
    end else if ((state == S_DONE) && done_ready && (op_cnt_q != '1)) begin
      op_cnt_q <= op_cnt_q + 32'd1;
    end
  end

  assign op_cnt_o = op_cnt_q;
`endif

endmodule

// File: tb/tb_pe_uno_ctrl.sv
// Directed bench for pe_uno_ctrl: cycle-exact phase timing, DONE stall,
// zero iteration count, async abort; perf counter when UNO_CTRL_PERF_EN.
module tb_pe_uno_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [15:0] req_x = '0;
  logic [3:0]  req_iter = '0;
  logic [1:0]  gemm_uno_o;
  logic [15:0] x_o;
  logic        acc_clr_o;
  logic        acc_en_o;
  logic [3:0]  iter_idx_o;
  logic        done_valid;
  logic        done_ready = 1'b0;
  logic        busy_o;
`ifdef UNO_CTRL_PERF_EN
  logic [31:0] op_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  pe_uno_ctrl #(.MUL_BW(16), .ITER_BW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_iter   (req_iter),
    .gemm_uno_o (gemm_uno_o),
    .x_o        (x_o),
    .acc_clr_o  (acc_clr_o),
    .acc_en_o   (acc_en_o),
    .iter_idx_o (iter_idx_o),
    .done_valid (done_valid),
    .done_ready (done_ready),
    .busy_o     (busy_o)
`ifdef UNO_CTRL_PERF_EN
    ,
    .op_cnt_o   (op_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rdy clr en idx dv busy
  task automatic ctl(input string tag, input logic rdy, input logic clr,
                     input logic en, input logic [3:0] idx,
                     input logic dv, input logic bsy);
    chk(tag, {req_ready, acc_clr_o, acc_en_o, iter_idx_o, done_valid, busy_o},
        {rdy, clr, en, idx, dv, bsy});
  endtask

  task automatic accept(input logic [1:0] op, input logic [15:0] x,
                        input logic [3:0] it);
    req_valid = 1'b1;
    req_op = op;
    req_x = x;
    req_iter = it;
    step();
    req_valid = 1'b0;
  endtask

`ifdef UNO_CTRL_PERF_EN
  task automatic run_op(input string tag);
    int k;
    accept(2'b00, 16'h0001, 4'd1);
    k = 0;
    while (!done_valid && k < 20) begin
      step();
      k++;
    end
    chk({tag, "_done"}, {63'd0, done_valid}, 64'd1);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
  endtask
`endif

  initial begin
    #2;
    ctl("reset_async", 1, 0, 0, 0, 0, 0);
    chk("reset_dp", {gemm_uno_o, x_o}, 64'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // log, N=3: offset 1, iter 2-4, drain 5, done 6
    accept(2'b11, 16'h0400, 4'd3);
    ctl("log_c1_offset", 0, 1, 0, 0, 0, 1);
    chk("log_latch", {gemm_uno_o, x_o}, {2'b11, 16'h0400});
    step();
    ctl("log_c2_it0", 0, 0, 1, 0, 0, 1);
    step();
    ctl("log_c3_it1", 0, 0, 1, 1, 0, 1);
    step();
    ctl("log_c4_it2", 0, 0, 1, 2, 0, 1);
    step();
    ctl("log_c5_drain", 0, 0, 0, 0, 0, 1);
    step();
    ctl("log_c6_done", 0, 0, 0, 0, 1, 1);
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    ctl("log_c7_idle", 1, 0, 0, 0, 0, 0);

    // gemm, N=2: clear with first accumulate, done 4
    accept(2'b00, 16'h1234, 4'd2);
    ctl("gemm_c1_it0", 0, 1, 1, 0, 0, 1);
    chk("gemm_latch", {gemm_uno_o, x_o}, {2'b00, 16'h1234});
    step();
    ctl("gemm_c2_it1", 0, 0, 1, 1, 0, 1);
    step();
    ctl("gemm_c3_drain", 0, 0, 0, 0, 0, 1);
    step();
    ctl("gemm_c4_done", 0, 0, 0, 0, 1, 1);
    req_valid = 1'b1;
    req_op = 2'b10;
    req_x = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      ctl($sformatf("stall_%0d", i), 0, 0, 0, 0, 1, 1);
    end
    chk("stall_op_held", {gemm_uno_o, x_o}, {2'b00, 16'h1234});
    req_valid = 1'b0;
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    ctl("stall_release", 1, 0, 0, 0, 0, 0);

    // div, iter=0 treated as 1; early done_ready is ignored
    done_ready = 1'b1;
    accept(2'b01, 16'hFFFE, 4'd0);
    ctl("div_c1_offset", 0, 1, 0, 0, 0, 1);
    step();
    ctl("div_c2_it0", 0, 0, 1, 0, 0, 1);
    step();
    ctl("div_c3_drain", 0, 0, 0, 0, 0, 1);
    step();
    ctl("div_c4_done", 0, 0, 0, 0, 1, 1);
    step();
    done_ready = 1'b0;
    ctl("div_c5_idle", 1, 0, 0, 0, 0, 0);

    // async abort during ITER index 1
    accept(2'b10, 16'h0055, 4'd4);
    step();
    step();
    ctl("abort_pre_it1", 0, 0, 1, 1, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    ctl("abort_async", 1, 0, 0, 0, 0, 0);
    chk("abort_dp", {gemm_uno_o, x_o}, 64'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      ctl($sformatf("abort_quiet_%0d", i), 1, 0, 0, 0, 0, 0);
    end

`ifdef UNO_CTRL_PERF_EN
    chk("perf_reset", {32'd0, op_cnt_o}, 64'd0);
    run_op("perf1");
    run_op("perf2");
    run_op("perf3");
    chk("perf_three", {32'd0, op_cnt_o}, 64'd3);
    dut.op_cnt_q = 32'hFFFF_FFFF;
    #1;
    run_op("perf_sat");
    chk("perf_saturate", {32'd0, op_cnt_o}, 64'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
